mux3_arbiter: RTL and testbench

MUX3_ARBITER -- requirements
Module: mux3_arbiter

---
 rtl/mux3_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mux3_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux3_arbiter.sv
// Three-requester burst arbiter driving a mux3 select, with round-robin fairness and a per-grant burst limit.
// Build option: define MUX3_ARB_FIXED_PRIO_EN for fixed priority 0>1>2 (no last-winner pointer).
module mux3_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [2:0] last,
   input  logic       dn_ready,
   output logic [1:0] sel,
   output logic [2:0] gnt,
   output logic       out_valid,
   output logic [3:0] beat_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

   // Winner search; result is {found, index}, index 3 when nobody requests.
`ifdef MUX3_ARB_FIXED_PRIO_EN
   function automatic logic [2:0] pick(input logic [2:0] r);
      logic [2:0] res;
      res = {1'b0, 2'd3};
      for (int k = 2; k >= 0; k--) begin
         if (r[k]) begin
            res = {1'b1, 2'(k)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction
`else
   // Later iterations overwrite earlier ones, so the first candidate after ptr wins.
   function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] ptr);
      logic [2:0] res;
      logic [2:0] idx;
      res = {1'b0, 2'd3};
      for (int k = 3; k >= 1; k--) begin
         idx = {1'b0, ptr} + 3'(k);
         if (idx >= 3'd3) begin
            idx = idx - 3'd3;
         end else begin
            idx = idx;
         end
         if (r[idx[1:0]]) begin
            res = {1'b1, idx[1:0]};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction
`endif

   state_t     r_state;
   logic [1:0] r_sel;
   logic [2:0] r_gnt;
   logic [3:0] r_beat_cnt;

   state_t     w_state_nxt;
   logic [1:0] w_sel_nxt;
   logic [2:0] w_gnt_nxt;
   logic [3:0] w_beat_nxt;
   logic       w_req_g;
   logic       w_last_g;
   logic       w_xfer;
   logic       w_end;
   logic [2:0] w_pick;

`ifndef MUX3_ARB_FIXED_PRIO_EN
   logic [1:0] r_last_winner;
   logic [1:0] w_last_winner_nxt;
   logic [1:0] w_ptr;
`endif

   // gnt is zero in IDLE, so masking with it yields the granted requester's bits only.
   assign w_req_g   = |(req & r_gnt);
   assign w_last_g  = |(last & r_gnt);
   assign w_xfer    = w_req_g & dn_ready;
   assign out_valid = w_req_g;
   assign sel       = r_sel;
   assign gnt       = r_gnt;
   assign beat_cnt  = r_beat_cnt;

   // Grant ends on a final or burst-limit transfer, or when the granted requester withdraws.
   assign w_end = (r_state == ST_BUSY) &&
                  ((w_xfer && (w_last_g || ((r_beat_cnt + 4'd1) == LP_MAX))) || !w_req_g);

`ifdef MUX3_ARB_FIXED_PRIO_EN
   assign w_pick = pick(req);
`else
   // While BUSY the current grantee becomes last_winner on the same edge, so search from it.
   assign w_ptr  = (r_state == ST_BUSY) ? r_sel : r_last_winner;
   assign w_pick = pick(req, w_ptr);
`endif

   // Next-state and next-grant logic.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_gnt_nxt   = r_gnt;
      w_beat_nxt  = r_beat_cnt;
`ifndef MUX3_ARB_FIXED_PRIO_EN
      w_last_winner_nxt = r_last_winner;
`endif
      case (r_state)
         ST_IDLE: begin
            w_beat_nxt = 4'd0;
            if (w_pick[2]) begin
               w_state_nxt = ST_BUSY;
               w_sel_nxt   = w_pick[1:0];
               w_gnt_nxt   = 3'(3'b001 << w_pick[1:0]);
            end else begin
               w_state_nxt = ST_IDLE;
               w_sel_nxt   = 2'd3;
               w_gnt_nxt   = 3'b000;
            end
         end
         ST_BUSY: begin
            if (w_end) begin
               w_beat_nxt = 4'd0;
`ifndef MUX3_ARB_FIXED_PRIO_EN
               w_last_winner_nxt = r_sel;
`endif
               if (w_pick[2]) begin
                  w_state_nxt = ST_BUSY;
                  w_sel_nxt   = w_pick[1:0];
                  w_gnt_nxt   = 3'(3'b001 << w_pick[1:0]);
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_sel_nxt   = 2'd3;
                  w_gnt_nxt   = 3'b000;
               end
            end else if (w_xfer) begin
               w_beat_nxt = r_beat_cnt + 4'd1;
            end else begin
               w_beat_nxt = r_beat_cnt;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = 2'd3;
            w_gnt_nxt   = 3'b000;
            w_beat_nxt  = 4'd0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_sel      <= 2'd3;
         r_gnt      <= 3'b000;
         r_beat_cnt <= 4'd0;
`ifndef MUX3_ARB_FIXED_PRIO_EN
         r_last_winner <= 2'd2;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_gnt      <= w_gnt_nxt;
         r_beat_cnt <= w_beat_nxt;
`ifndef MUX3_ARB_FIXED_PRIO_EN
         r_last_winner <= w_last_winner_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_mux3_arbiter.sv
// Scoreboard bench for mux3_arbiter: stimulus queues the expected {sel, beat_cnt} of every transfer,
// a negedge monitor pops and compares on each out_valid && dn_ready.
module tb_mux3_arbiter;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic [2:0] last;
   logic       dn_ready;
   logic [1:0] sel;
   logic [2:0] gnt;
   logic       out_valid;
   logic [3:0] beat_cnt;

   typedef struct packed {
      logic [1:0] s;
      logic [3:0] b;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   mux3_arbiter #(.MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .dn_ready  (dn_ready),
      .sel       (sel),
      .gnt       (gnt),
      .out_valid (out_valid),
      .beat_cnt  (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int want);
      n_total++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input int b);
      exp_t e;
      e.s = 2'(s);
      e.b = 4'(b);
      q.push_back(e);
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_sel"}, sel, 3);
      chk({nm, "_gnt"}, gnt, 0);
      chk({nm, "_beat"}, beat_cnt, 0);
   endtask

   // Transfer monitor.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && dn_ready === 1'b1) begin
         if (q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_xfer: got sel=%0d beat=%0d required no transfer (t=%0t)",
                     sel, beat_cnt, $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("xfer_sel", sel, e.s);
            chk("xfer_beat", beat_cnt, e.b);
            chk("xfer_gnt", gnt, 1 << e.s);
         end
      end
   end

   initial begin
      int g_seq[4];
`ifdef MUX3_ARB_FIXED_PRIO_EN
      g_seq = '{0, 0, 0, 0};
`else
      g_seq = '{0, 1, 2, 0};
`endif
      rst_n    = 1'b0;
      req      = 3'b111;
      last     = 3'b000;
      dn_ready = 1'b1;

      // Reset held two cycles with all requests high, then back-to-back bursts of 4.
      for (int i = 0; i < 4; i++) begin
         for (int b = 0; b < 4; b++) push(g_seq[i], b);
      end
      repeat (2) begin
         tick();
         chk_idle("reset");
         chk("reset_valid", out_valid, 0);
      end
      rst_n = 1'b1;
      tick();
      chk("first_gnt", gnt, 1);
      chk("first_sel", sel, 0);
      repeat (16) tick();
      req = 3'b000;
      tick();
      chk_idle("rr_idle");

      // Early last on the second transfer of requester 1.
      push(1, 0);
      push(1, 1);
      req = 3'b010;
      tick();
      chk("last_gnt", gnt, 2);
      tick();
      chk("last_beat1", beat_cnt, 1);
      last = 3'b010;
      tick();
      chk("last_clear", beat_cnt, 0);
      req  = 3'b000;
      last = 3'b000;
      tick();
      chk_idle("last_idle");

      // Stall requester 2 for five cycles mid-burst.
      for (int b = 0; b < 4; b++) push(2, b);
      req = 3'b100;
      tick();
      chk("stall_sel", sel, 2);
      tick();
      chk("stall_beat_pre", beat_cnt, 1);
      dn_ready = 1'b0;
      repeat (5) begin
         tick();
         chk("stall_beat_hold", beat_cnt, 1);
         chk("stall_sel_hold", sel, 2);
      end
      dn_ready = 1'b1;
      tick();
      chk("stall_resume2", beat_cnt, 2);
      tick();
      chk("stall_resume3", beat_cnt, 3);
      tick();
      chk("stall_limit_clear", beat_cnt, 0);
      req = 3'b000;
      tick();
      chk_idle("stall_idle");

      // Requester 0 withdraws after beat 1, grant passes to 1, then reset at beat 2.
      push(0, 0);
      push(1, 0);
      push(1, 1);
      req = 3'b011;
      tick();
      chk("wd_sel0", sel, 0);
      tick();
      chk("wd_beat1", beat_cnt, 1);
      req = 3'b010;
      tick();
      chk("wd_sel1", sel, 1);
      chk("wd_gnt1", gnt, 2);
      chk("wd_beat0", beat_cnt, 0);
      tick();
      chk("wd_b1", beat_cnt, 1);
      tick();
      chk("wd_b2", beat_cnt, 2);
      rst_n = 1'b0;
      tick();
      chk_idle("midrst");
      chk("midrst_valid", out_valid, 0);
      req   = 3'b000;
      rst_n = 1'b1;
      repeat (2) tick();
      chk("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
